// File: rtl/mode_switch_ctrl_if.sv
// Command/status bundle between the mode-request decoders and the mode-switch controller.
// The master side drives request pulses; the slave (controller) returns mode and motor status.
interface mode_switch_ctrl_if;
   logic       key_valid;
   logic [1:0] key_mode;
   logic       ir_valid;
   logic [7:0] ir_data;
   logic       bt_valid;
   logic [7:0] bt_data;
   logic [1:0] mode;
   logic [3:0] led;
   logic       motor_en;
   logic       busy;
   logic       halted;

   modport master (
      output key_valid, key_mode, ir_valid, ir_data, bt_valid, bt_data,
      input  mode, led, motor_en, busy, halted
   );

   modport slave (
      input  key_valid, key_mode, ir_valid, ir_data, bt_valid, bt_data,
      output mode, led, motor_en, busy, halted
   );
endinterface

// File: rtl/mode_switch_ctrl.sv
// Safe mode-transition controller: stops the motors, loads the new mode, waits a settle time,
// then re-enables the drivers. Arbitrates key/IR/BT requests and handles emergency stop.
module mode_switch_ctrl #(
   parameter int unsigned STOP_CYCLES   = 5_000_000,
   parameter int unsigned SETTLE_CYCLES = 2_500_000,
   parameter logic [7:0]  ESTOP_CODE    = 8'd64
) (
   input logic               clk,
   input logic               rst,
   mode_switch_ctrl_if.slave bus
);

   localparam int unsigned CntMax =
      ((STOP_CYCLES > SETTLE_CYCLES) ? STOP_CYCLES : SETTLE_CYCLES) - 1;
   localparam int unsigned CntW = (CntMax > 1) ? $clog2(CntMax + 1) : 1;
   localparam logic [CntW-1:0] StopLoad   = CntW'(STOP_CYCLES - 1);
   localparam logic [CntW-1:0] SettleLoad = CntW'(SETTLE_CYCLES - 1);

   typedef enum logic [1:0] {StRun, StStop, StSettle, StHalt} state_e;

   function automatic logic [3:0] led_of(input logic [1:0] m);
      return ~(4'b0001 << m);
   endfunction

   // {valid, mode}; codes outside the map are dropped.
   function automatic logic [2:0] decode_code(input logic [7:0] code);
      case (code)
         8'd69:   return 3'b100;
         8'd70:   return 3'b101;
         8'd71:   return 3'b110;
         8'd68:   return 3'b111;
         default: return 3'b000;
      endcase
   endfunction

   state_e          state_q, state_d;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic [1:0]      mode_q, mode_d;
   logic [3:0]      led_q, led_d;
   logic            motor_en_q, motor_en_d;
   logic            busy_q, busy_d;
   logic            halted_q, halted_d;
   logic [1:0]      target_q, target_d;
   logic            pend_valid_q, pend_valid_d;
   logic [1:0]      pend_mode_q, pend_mode_d;

   logic [2:0] ir_dec, bt_dec;
   logic       estop;
   logic       req_valid;
   logic [1:0] req_mode;
   logic       pend_hit;
   logic [1:0] pend_sel;

   always_comb begin
      ir_dec = decode_code(bus.ir_data);
      bt_dec = decode_code(bus.bt_data);
      estop  = (bus.ir_valid && (bus.ir_data == ESTOP_CODE)) ||
               (bus.bt_valid && (bus.bt_data == ESTOP_CODE));
      req_valid = 1'b0;
      req_mode  = 2'd0;
      if (bus.key_valid) begin
         req_valid = 1'b1;
         req_mode  = bus.key_mode;
      end else if (bus.ir_valid && ir_dec[2]) begin
         req_valid = 1'b1;
         req_mode  = ir_dec[1:0];
      end else if (bus.bt_valid && bt_dec[2]) begin
         req_valid = 1'b1;
         req_mode  = bt_dec[1:0];
      end
   end

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      mode_d       = mode_q;
      led_d        = led_q;
      motor_en_d   = motor_en_q;
      busy_d       = busy_q;
      halted_d     = halted_q;
      target_d     = target_q;
      pend_valid_d = pend_valid_q;
      pend_mode_d  = pend_mode_q;
      // A request arriving on the settle-expiry edge is the newest pending one.
      pend_hit     = req_valid || pend_valid_q;
      pend_sel     = req_valid ? req_mode : pend_mode_q;

      unique case (state_q)
         StRun: begin
            if (req_valid && (req_mode != mode_q)) begin
               state_d    = StStop;
               target_d   = req_mode;
               cnt_d      = StopLoad;
               motor_en_d = 1'b0;
               busy_d     = 1'b1;
            end
         end
         StStop: begin
            cnt_d = cnt_q - CntW'(1);
            if (req_valid) target_d = req_mode;
            if (cnt_q == '0) begin
               mode_d  = target_d;
               led_d   = led_of(target_d);
               state_d = StSettle;
               cnt_d   = SettleLoad;
            end
         end
         StSettle: begin
            cnt_d = cnt_q - CntW'(1);
            if (req_valid) begin
               pend_valid_d = 1'b1;
               pend_mode_d  = req_mode;
            end
            if (cnt_q == '0) begin
               pend_valid_d = 1'b0;
               pend_mode_d  = 2'd0;
               if (pend_hit && (pend_sel != mode_q)) begin
                  state_d  = StStop;
                  target_d = pend_sel;
                  cnt_d    = StopLoad;
               end else begin
                  state_d    = StRun;
                  motor_en_d = 1'b1;
                  busy_d     = 1'b0;
               end
            end
         end
         StHalt: begin
            // Motors are already stopped, so recovery goes straight to SETTLE.
            if (req_valid) begin
               mode_d   = req_mode;
               led_d    = led_of(req_mode);
               halted_d = 1'b0;
               busy_d   = 1'b1;
               state_d  = StSettle;
               cnt_d    = SettleLoad;
            end
         end
      endcase

      if (estop) begin
         state_d      = StHalt;
         cnt_d        = '0;
         mode_d       = mode_q;
         led_d        = led_q;
         motor_en_d   = 1'b0;
         busy_d       = 1'b0;
         halted_d     = 1'b1;
         target_d     = 2'd0;
         pend_valid_d = 1'b0;
         pend_mode_d  = 2'd0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= StSettle;
         cnt_q        <= SettleLoad;
         mode_q       <= 2'd0;
         led_q        <= 4'b1110;
         motor_en_q   <= 1'b0;
         busy_q       <= 1'b1;
         halted_q     <= 1'b0;
         target_q     <= 2'd0;
         pend_valid_q <= 1'b0;
         pend_mode_q  <= 2'd0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         mode_q       <= mode_d;
         led_q        <= led_d;
         motor_en_q   <= motor_en_d;
         busy_q       <= busy_d;
         halted_q     <= halted_d;
         target_q     <= target_d;
         pend_valid_q <= pend_valid_d;
         pend_mode_q  <= pend_mode_d;
      end
   end

   assign bus.mode     = mode_q;
   assign bus.led      = led_q;
   assign bus.motor_en = motor_en_q;
   assign bus.busy     = busy_q;
   assign bus.halted   = halted_q;

endmodule

// File: tb/tb_mode_switch_ctrl.sv
// Bench for mode_switch_ctrl with short STOP/SETTLE times; expected mode changes are queued
// when a request is driven and popped when the DUT's mode output actually moves.
module tb_mode_switch_ctrl;

   localparam int unsigned StopCycles   = 4;
   localparam int unsigned SettleCycles = 3;

   typedef struct {
      logic [1:0] mode;
      logic [3:0] led;
      int         lat;
   } exp_t;

   logic clk;
   logic rst;
   int   checks;
   int   errors;
   exp_t exp_q[$];

   mode_switch_ctrl_if bus();

   mode_switch_ctrl #(
      .STOP_CYCLES  (StopCycles),
      .SETTLE_CYCLES(SettleCycles),
      .ESTOP_CODE   (8'd64)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input bit kv, input logic [1:0] km, input bit iv, input logic [7:0] id,
                       input bit bv, input logic [7:0] bd);
      bus.key_valid = kv;
      bus.key_mode  = km;
      bus.ir_valid  = iv;
      bus.ir_data   = id;
      bus.bt_valid  = bv;
      bus.bt_data   = bd;
      tick();
      bus.key_valid = 1'b0;
      bus.ir_valid  = 1'b0;
      bus.bt_valid  = 1'b0;
   endtask

   // Edges until mode moves (bounded); also reports whether motor_en rose on the way.
   task automatic await_mode(output int n, output bit to, output bit en_seen);
      logic [1:0] old;
      old     = bus.mode;
      n       = 0;
      to      = 1'b0;
      en_seen = 1'b0;
      while ((bus.mode === old) && (n < 40)) begin
         tick();
         n++;
         if (bus.motor_en === 1'b1) en_seen = 1'b1;
      end
      if (bus.mode === old) to = 1'b1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick();
      tick();
      checks++;
      if ({bus.mode, bus.led, bus.motor_en, bus.busy, bus.halted} !== {2'd0, 4'b1110, 3'b010}) begin
         errors++;
         $display("FAIL reset_vals: got mode=%0d led=%b en=%b busy=%b halted=%b, want 0 1110 0 1 0",
                  bus.mode, bus.led, bus.motor_en, bus.busy, bus.halted);
      end
      rst = 1'b0;
      tick();
      tick();
      checks++;
      if (bus.motor_en !== 1'b0) begin
         errors++;
         $display("FAIL reset_en_edge2: got motor_en=%b want 0", bus.motor_en);
      end
      tick();
      checks++;
      if ({bus.motor_en, bus.busy, bus.mode, bus.led} !== {2'b10, 2'd0, 4'b1110}) begin
         errors++;
         $display("FAIL reset_run_edge3: got en=%b busy=%b mode=%0d led=%b want 1 0 0 1110",
                  bus.motor_en, bus.busy, bus.mode, bus.led);
      end
   endtask

   task automatic test_ignored();
      logic [7:0] codes[3];
      codes[0] = 8'd99;
      codes[1] = 8'd69;
      codes[2] = 8'd0;
      foreach (codes[i]) begin
         send(1'b0, 2'd0, 1'b1, codes[i], 1'b1, codes[i]);
         checks++;
         if ({bus.mode, bus.motor_en, bus.busy} !== {2'd0, 2'b10}) begin
            errors++;
            $display("FAIL ignored_code%0d: got mode=%0d en=%b busy=%b want 0 1 0",
                     codes[i], bus.mode, bus.motor_en, bus.busy);
         end
      end
      send(1'b1, 2'd0, 1'b0, 8'd0, 1'b0, 8'd0);
      checks++;
      if ({bus.motor_en, bus.busy} !== 2'b10) begin
         errors++;
         $display("FAIL ignored_same_key: got en=%b busy=%b want 1 0", bus.motor_en, bus.busy);
      end
   endtask

   task automatic test_single_change();
      int n;
      bit to, en;
      exp_t e;
      send(1'b0, 2'd0, 1'b1, 8'd70, 1'b0, 8'd0);
      exp_q.push_back('{mode: 2'd1, led: 4'b1101, lat: 4});
      checks++;
      if ({bus.motor_en, bus.busy} !== 2'b01) begin
         errors++;
         $display("FAIL chg_accept: got en=%b busy=%b want 0 1", bus.motor_en, bus.busy);
      end
      await_mode(n, to, en);
      checks++;
      if (to || exp_q.size() == 0) begin
         errors++;
         $display("FAIL chg_timeout: got mode=%0d after %0d edges, want a change", bus.mode, n);
      end else begin
         e = exp_q.pop_front();
         if (bus.mode !== e.mode || bus.led !== e.led || n != e.lat) begin
            errors++;
            $display("FAIL chg_result: got mode=%0d led=%b lat=%0d want %0d %b %0d",
                     bus.mode, bus.led, n, e.mode, e.led, e.lat);
         end
      end
      tick();
      tick();
      checks++;
      if (bus.motor_en !== 1'b0) begin
         errors++;
         $display("FAIL chg_en_early: got motor_en=%b at E+6 want 0", bus.motor_en);
      end
      tick();
      checks++;
      if ({bus.motor_en, bus.busy} !== 2'b10) begin
         errors++;
         $display("FAIL chg_run: got en=%b busy=%b at E+7 want 1 0", bus.motor_en, bus.busy);
      end
   endtask

   task automatic test_arbitration();
      int n;
      bit to, en;
      exp_t e;
      send(1'b1, 2'd2, 1'b1, 8'd71, 1'b1, 8'd68);
      exp_q.push_back('{mode: 2'd2, led: 4'b1011, lat: 4});
      await_mode(n, to, en);
      checks++;
      if (to || exp_q.size() == 0) begin
         errors++;
         $display("FAIL arb_timeout: got mode=%0d after %0d edges, want a change", bus.mode, n);
      end else begin
         e = exp_q.pop_front();
         if (bus.mode !== e.mode || bus.led !== e.led || n != e.lat) begin
            errors++;
            $display("FAIL arb_key_wins: got mode=%0d led=%b lat=%0d want %0d %b %0d",
                     bus.mode, bus.led, n, e.mode, e.led, e.lat);
         end
      end
      repeat (3) tick();
      send(1'b1, 2'd0, 1'b0, 8'd0, 1'b1, 8'd64);
      checks++;
      if ({bus.halted, bus.motor_en, bus.busy, bus.mode, bus.led} !== {3'b100, 2'd2, 4'b1011}) begin
         errors++;
         $display("FAIL arb_estop: got halted=%b en=%b busy=%b mode=%0d led=%b want 1 0 0 2 1011",
                  bus.halted, bus.motor_en, bus.busy, bus.mode, bus.led);
      end
      send(1'b0, 2'd0, 1'b1, 8'd64, 1'b0, 8'd0);
      checks++;
      if ({bus.halted, bus.busy, bus.mode} !== {2'b10, 2'd2}) begin
         errors++;
         $display("FAIL halt_repeat_estop: got halted=%b busy=%b mode=%0d want 1 0 2",
                  bus.halted, bus.busy, bus.mode);
      end
      send(1'b1, 2'd2, 1'b0, 8'd0, 1'b0, 8'd0);
      checks++;
      if ({bus.halted, bus.busy, bus.motor_en, bus.mode} !== {3'b010, 2'd2}) begin
         errors++;
         $display("FAIL halt_same_mode: got halted=%b busy=%b en=%b mode=%0d want 0 1 0 2",
                  bus.halted, bus.busy, bus.motor_en, bus.mode);
      end
      repeat (3) tick();
      checks++;
      if ({bus.motor_en, bus.busy} !== 2'b10) begin
         errors++;
         $display("FAIL halt_recover_run: got en=%b busy=%b want 1 0", bus.motor_en, bus.busy);
      end
   endtask

   task automatic test_back_to_back();
      int n;
      bit to, en;
      exp_t e;
      send(1'b1, 2'd1, 1'b0, 8'd0, 1'b0, 8'd0);
      // One STOP edge already consumed by the bt pulse below.
      send(1'b0, 2'd0, 1'b0, 8'd0, 1'b1, 8'd68);
      exp_q.push_back('{mode: 2'd3, led: 4'b0111, lat: 3});
      await_mode(n, to, en);
      checks++;
      if (to || exp_q.size() == 0) begin
         errors++;
         $display("FAIL b2b_first_timeout: got mode=%0d after %0d edges", bus.mode, n);
      end else begin
         e = exp_q.pop_front();
         if (bus.mode !== e.mode || bus.led !== e.led || n != e.lat) begin
            errors++;
            $display("FAIL b2b_retarget: got mode=%0d led=%b lat=%0d want %0d %b %0d",
                     bus.mode, bus.led, n, e.mode, e.led, e.lat);
         end
      end
      send(1'b0, 2'd0, 1'b1, 8'd70, 1'b0, 8'd0);
      exp_q.push_back('{mode: 2'd1, led: 4'b1101, lat: 6});
      await_mode(n, to, en);
      checks++;
      if (to || exp_q.size() == 0) begin
         errors++;
         $display("FAIL b2b_second_timeout: got mode=%0d after %0d edges", bus.mode, n);
      end else begin
         e = exp_q.pop_front();
         if (bus.mode !== e.mode || bus.led !== e.led || n != e.lat || en) begin
            errors++;
            $display("FAIL b2b_pending: got mode=%0d led=%b lat=%0d en_rose=%b want %0d %b %0d 0",
                     bus.mode, bus.led, n, en, e.mode, e.led, e.lat);
         end
      end
      repeat (3) tick();
      checks++;
      if ({bus.motor_en, bus.busy, bus.mode} !== {2'b10, 2'd1}) begin
         errors++;
         $display("FAIL b2b_run: got en=%b busy=%b mode=%0d want 1 0 1",
                  bus.motor_en, bus.busy, bus.mode);
      end
   endtask

   task automatic test_estop_settle();
      int n;
      bit to, en;
      exp_t e;
      send(1'b1, 2'd3, 1'b0, 8'd0, 1'b0, 8'd0);
      await_mode(n, to, en);
      send(1'b0, 2'd0, 1'b1, 8'd64, 1'b0, 8'd0);
      checks++;
      if ({bus.halted, bus.motor_en, bus.busy, bus.mode, bus.led} !== {3'b100, 2'd3, 4'b0111}) begin
         errors++;
         $display("FAIL estop_settle: got halted=%b en=%b busy=%b mode=%0d led=%b want 1 0 0 3 0111",
                  bus.halted, bus.motor_en, bus.busy, bus.mode, bus.led);
      end
      bus.key_valid = 1'b1;
      bus.key_mode  = 2'd0;
      exp_q.push_back('{mode: 2'd0, led: 4'b1110, lat: 1});
      await_mode(n, to, en);
      bus.key_valid = 1'b0;
      checks++;
      if (to || exp_q.size() == 0) begin
         errors++;
         $display("FAIL halt_exit_timeout: got mode=%0d after %0d edges", bus.mode, n);
      end else begin
         e = exp_q.pop_front();
         if (bus.mode !== e.mode || bus.led !== e.led || n != e.lat || bus.halted !== 1'b0) begin
            errors++;
            $display("FAIL halt_exit: got mode=%0d led=%b lat=%0d halted=%b want %0d %b %0d 0",
                     bus.mode, bus.led, n, bus.halted, e.mode, e.led, e.lat);
         end
      end
      tick();
      tick();
      checks++;
      if (bus.motor_en !== 1'b0) begin
         errors++;
         $display("FAIL halt_exit_en_early: got motor_en=%b want 0", bus.motor_en);
      end
      tick();
      checks++;
      if (bus.motor_en !== 1'b1) begin
         errors++;
         $display("FAIL halt_exit_en: got motor_en=%b three edges later, want 1", bus.motor_en);
      end
   endtask

   task automatic test_reset_mid();
      send(1'b1, 2'd3, 1'b0, 8'd0, 1'b0, 8'd0);
      tick();
      rst = 1'b1;
      #1;
      checks++;
      if ({bus.mode, bus.led, bus.motor_en, bus.busy, bus.halted} !== {2'd0, 4'b1110, 3'b010}) begin
         errors++;
         $display("FAIL reset_async: got mode=%0d led=%b en=%b busy=%b halted=%b want 0 1110 0 1 0",
                  bus.mode, bus.led, bus.motor_en, bus.busy, bus.halted);
      end
      tick();
      rst = 1'b0;
      tick();
      tick();
      checks++;
      if (bus.motor_en !== 1'b0) begin
         errors++;
         $display("FAIL reset_mid_en_early: got motor_en=%b want 0", bus.motor_en);
      end
      tick();
      checks++;
      if ({bus.motor_en, bus.busy} !== 2'b10) begin
         errors++;
         $display("FAIL reset_mid_run: got en=%b busy=%b want 1 0", bus.motor_en, bus.busy);
      end
      repeat (6) tick();
      checks++;
      if ({bus.mode, bus.led, bus.motor_en} !== {2'd0, 4'b1110, 1'b1}) begin
         errors++;
         $display("FAIL reset_mid_no_partial: got mode=%0d led=%b en=%b want 0 1110 1",
                  bus.mode, bus.led, bus.motor_en);
      end
   endtask

   initial begin
      checks        = 0;
      errors        = 0;
      rst           = 1'b1;
      bus.key_valid = 1'b0;
      bus.key_mode  = 2'd0;
      bus.ir_valid  = 1'b0;
      bus.ir_data   = 8'd0;
      bus.bt_valid  = 1'b0;
      bus.bt_data   = 8'd0;
      test_reset();
      test_ignored();
      test_single_change();
      test_arbitration();
      test_back_to_back();
      test_estop_settle();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
